// File: rtl/axis_bridge_pkg.sv
// Shared definitions for the AXIS bridge TX path: count-word field positions
// and the byte-count FSM state encoding.
package axis_bridge_pkg;

  localparam int CNT_LEN_MSB  = 15;
  localparam int CNT_OVS_BIT  = 16;
  localparam int CNT_RUNT_BIT = 17;
  localparam int CNT_KERR_BIT = 18;
  localparam int CNT_SEQ_LSB  = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } bc_state_e;

endpackage

// File: rtl/axis_keep_decode.sv
// Combinational tkeep decode: number of enabled bytes and whether the enables
// form a contiguous low-aligned run (0..01..1).
module axis_keep_decode #(
  parameter int KEEP_W = 8,
  parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] keep_i,
  output logic [CNT_W-1:0]  bytes_o,
  output logic              contig_o
);

  logic [KEEP_W-1:0] keep_inc;

  always_comb begin
    bytes_o = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      bytes_o = bytes_o + CNT_W'(keep_i[i]);
    end
  end

  // A low-aligned run of ones has no carry landing on a set bit when incremented.
  assign keep_inc = keep_i + {{(KEEP_W-1){1'b0}}, 1'b1};
  assign contig_o = ((keep_i & keep_inc) == '0);

endmodule

// File: rtl/axis_tx_bytecnt.sv
// TX AXI-Stream tap: passes the stream through unchanged, measures each frame's
// byte length and writes one count/status word per frame into the count FIFO.
import axis_bridge_pkg::*;

module axis_tx_bytecnt #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int MIN_BYTES = 60,
  parameter int MAX_BYTES = 9600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              cnt_wren,
  output logic [31:0]       cnt_data,
  input  logic              cnt_wrfull,
  output logic [31:0]       frm_total
);

  localparam int CW = $clog2(KEEP_W + 1);

  bc_state_e   state_q, state_d;
  logic [16:0] acc_q, acc_d;
  logic        kerr_q, kerr_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  seq_q, seq_d;
  logic [31:0] frm_total_q, frm_total_d;

  logic [CW-1:0] beat_bytes;
  logic          beat_contig;
  logic          stall;
  logic          beat;
  logic          beat_kerr;
  logic          frame_kerr;
  logic [16:0]   acc_base;
  logic [17:0]   sum_wide;
  logic [16:0]   total;
  logic [15:0]   len_clamped;
  logic [31:0]   word;

  axis_keep_decode #(
    .KEEP_W (KEEP_W),
    .CNT_W  (CW)
  ) u_keep_decode (
    .keep_i   (s_tkeep),
    .bytes_o  (beat_bytes),
    .contig_o (beat_contig)
  );

  // Handshake: a beat transfers on both sides in the same cycle when
  // s_tvalid & s_tready; ready never depends on valid. While a count word
  // waits on a full FIFO the whole stream is held so no word can be lost.
  assign stall    = pend_valid_q & cnt_wrfull;
  assign s_tready = m_tready & ~stall & ~reset;
  assign m_tvalid = s_tvalid & ~stall & ~reset;
  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign m_tlast  = s_tlast;
  assign beat     = s_tvalid & s_tready;

  assign cnt_wren  = pend_valid_q & ~cnt_wrfull;
  assign cnt_data  = pend_q;
  assign frm_total = frm_total_q;

  assign beat_kerr  = ~beat_contig
                    | (~s_tlast & (s_tkeep != '1))
                    | (s_tlast & (s_tkeep == '0));
  assign frame_kerr = ((state_q == IN_PKT) & kerr_q) | beat_kerr;

  // Saturating accumulate; in IDLE the frame starts from this beat alone.
  assign acc_base    = (state_q == IN_PKT) ? acc_q : 17'd0;
  assign sum_wide    = {1'b0, acc_base} + 18'(beat_bytes);
  assign total       = sum_wide[17] ? 17'h1FFFF : sum_wide[16:0];
  assign len_clamped = total[16] ? 16'hFFFF : total[15:0];

  always_comb begin
    word                           = '0;
    word[CNT_LEN_MSB:0]            = len_clamped;
    word[CNT_OVS_BIT]              = (total > 17'(MAX_BYTES));
    word[CNT_RUNT_BIT]             = (total < 17'(MIN_BYTES));
    word[CNT_KERR_BIT]             = frame_kerr;
    word[CNT_SEQ_LSB +: 8]         = seq_q;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    kerr_d       = kerr_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    seq_d        = seq_q;
    frm_total_d  = frm_total_q;
    if (cnt_wren) begin
      pend_valid_d = 1'b0;
    end
    // A closing beat in the same cycle as a write-out reloads pend, keeping it valid.
    if (beat) begin
      if (s_tlast) begin
        state_d      = IDLE;
        acc_d        = '0;
        kerr_d       = 1'b0;
        pend_d       = word;
        pend_valid_d = 1'b1;
        seq_d        = seq_q + 8'd1;
        frm_total_d  = frm_total_q + 32'd1;
      end else begin
        state_d = IN_PKT;
        acc_d   = total;
        kerr_d  = frame_kerr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      kerr_q       <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      seq_q        <= '0;
      frm_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      kerr_q       <= kerr_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seq_q        <= seq_d;
      frm_total_q  <= frm_total_d;
    end
  end

endmodule
